// File: rtl/riscv_lsu_pkg.sv
// Shared load/store decode definitions: funct3 size codes, LSU state enum and
// a helper that collapses a size code to its access width.
// Latency: n/a (package).  Backpressure: n/a (package).
package riscv_lsu_pkg;

  // funct3 encodings for loads/stores
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_width_e;

  // Unused encodings (3, 6, 7) fall through to word width.
  function automatic lsu_width_e ldst_width(input logic [2:0] size);
    lsu_width_e w;
    case (size)
      LDST_B, LDST_BU: w = SZ_BYTE;
      LDST_H, LDST_HU: w = SZ_HALF;
      default:         w = SZ_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/riscv_lsu_load_ext.sv
// Load extension: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it to 32 bits.  Purely combinational, no backpressure.
// Ports: word_i (memory word), off_i (byte offset), size_i (funct3), res_o (result).
module lsu_load_ext
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  output logic [31:0] res_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      LDST_B:  res_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: res_o = {24'h0, byte_sel};
      LDST_H:  res_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: res_o = {16'h0, half_sel};
      default: res_o = word_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one memory request per core access, lane steering for
// stores, lane extraction for loads, misalignment detection.
// Latency: 2 cycles minimum (request, response); stalls the core until mem_ready_i.
// Ports: core_* (core side request/result/stall), mem_* (memory side), misalign_o.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;

  lsu_width_e  width;
  logic        misaligned;
  logic [31:0] ext_rd;

  always_comb begin
    width = ldst_width(core_size_i);
    case (width)
      SZ_HALF: misaligned = core_addr_i[0];
      SZ_WORD: misaligned = (core_addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      off_q   <= 2'b00;
      size_q  <= 3'b000;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      we_q    <= we_d;
    end
  end

  // Next-state logic; access attributes are captured on issue because the
  // response is decoded a cycle or more later.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (core_req_i && !misaligned) begin
          state_d = ST_WAIT;
          off_d   = core_addr_i[1:0];
          size_d  = core_size_i;
          we_d    = core_we_i;
        end
      end
      ST_WAIT: begin
        if (mem_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_load_ext u_load_ext (
    .word_i (mem_rd_i),
    .off_i  (off_q),
    .size_i (size_q),
    .res_o  (ext_rd)
  );

  // Output logic; everything handshake-related is held low while reset is
  // asserted so a pending core request cannot leak out during reset.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    core_stall_o = 1'b0;
    misalign_o   = 1'b0;
    core_rd_o    = 32'h0;
    if (rst_ni) begin
      case (state_q)
        ST_IDLE: begin
          if (core_req_i) begin
            if (misaligned) begin
              misalign_o = 1'b1;
            end else begin
              mem_req_o    = 1'b1;
              mem_we_o     = core_we_i;
              core_stall_o = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          core_stall_o = !mem_ready_i;
          if (mem_ready_i && !we_q) core_rd_o = ext_rd;
        end
        default: ;
      endcase
    end
  end

  // Lane steering follows the live core inputs, which the core holds stable
  // for the whole access.
  always_comb begin
    case (width)
      SZ_BYTE: begin
        mem_be_o = 4'b0001 << core_addr_i[1:0];
        mem_wd_o = {4{core_wd_i[7:0]}};
      end
      SZ_HALF: begin
        mem_be_o = 4'b0011 << core_addr_i[1:0];
        mem_wd_o = {2{core_wd_i[15:0]}};
      end
      default: begin
        mem_be_o = 4'b1111;
        mem_wd_o = core_wd_i;
      end
    endcase
  end

  assign mem_addr_o = core_addr_i;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed accesses push expected memory requests,
// responses and misalignment flags into queues; a negedge monitor pops them.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, misalign_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  riscv_lsu dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .misalign_o   (misalign_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] addr;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] mis_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every DUT event must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (mem_req_o === 1'b1) begin
      if (req_q.size() == 0) chk("spurious_mem_req", 32'(mem_req_o), 32'd0);
      else begin
        req_t e;
        e = req_q.pop_front();
        chk("mem_be", 32'(mem_be_o), 32'(e.be));
        chk("mem_wd", mem_wd_o, e.wd);
        chk("mem_we", 32'(mem_we_o), 32'(e.we));
        chk("mem_addr", mem_addr_o, e.addr);
      end
    end
    if (misalign_o === 1'b1) begin
      if (mis_q.size() == 0) chk("spurious_misalign", 32'(misalign_o), 32'd0);
      else begin
        logic [31:0] a;
        a = mis_q.pop_front();
        chk("misalign_addr", mem_addr_o, a);
        chk("misalign_stall", 32'(core_stall_o), 32'd0);
      end
    end
    if (mem_ready_i === 1'b1) begin
      if (rsp_q.size() == 0) chk("spurious_response", 32'(mem_ready_i), 32'd0);
      else begin
        logic [31:0] r;
        r = rsp_q.pop_front();
        chk("core_rd", core_rd_o, r);
        chk("release_stall", 32'(core_stall_o), 32'd0);
      end
    end
  end

  task automatic idle_inputs();
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = LDST_W;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
    mem_rd_i    = 32'h0;
    mem_ready_i = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the release edge so
  // a following call issues back-to-back.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    int   stalls;
    req_t e;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'h0;
    e.be = exp_be; e.wd = exp_wd; e.we = we; e.addr = addr;
    req_q.push_back(e);
    rsp_q.push_back(exp_rd);
    stalls = 0;
    @(negedge clk_i) stalls += int'(core_stall_o);
    for (int i = 0; i < waits; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i) stalls += int'(core_stall_o);
    end
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1;
    mem_rd_i    = rdata;
    @(negedge clk_i) stalls += int'(core_stall_o);
    @(posedge clk_i); #1;
    idle_inputs();
    chk("stall_cycles", 32'(stalls), 32'(waits + 1));
  endtask

  task automatic misaligned_access(input logic [2:0] size, input logic [31:0] addr);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = size;
    core_addr_i = addr;
    mis_q.push_back(addr);
    @(negedge clk_i);
    chk("misalign_flag", 32'(misalign_o), 32'd1);
    chk("misalign_no_req", 32'(mem_req_o), 32'd0);
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_ni      = 1'b0;
    // Core request held during reset must not escape.
    core_req_i  = 1'b1;
    core_addr_i = 32'h0000_0100;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_stall", 32'(core_stall_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_rd", core_rd_o, 32'd0);
    @(posedge clk_i); #1;
    idle_inputs();
    rst_ni = 1'b1;

    // we, size, addr, wd, rdata, waits, be, wd, rd
    access(1'b1, LDST_B,  32'h103, 32'h0000_00A5, 32'h0,         0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    access(1'b0, LDST_B,  32'h102, 32'h0,         32'h12F4_5678, 0, 4'b0100, 32'h0,         32'hFFFF_FFF4);
    access(1'b0, LDST_BU, 32'h102, 32'h0,         32'h12F4_5678, 0, 4'b0100, 32'h0,         32'h0000_00F4);
    access(1'b0, LDST_H,  32'h102, 32'h0,         32'h8001_5678, 0, 4'b1100, 32'h0,         32'hFFFF_8001);
    access(1'b0, LDST_HU, 32'h102, 32'h0,         32'h8001_5678, 0, 4'b1100, 32'h0,         32'h0000_8001);
    access(1'b0, LDST_W,  32'h100, 32'h0,         32'hDEAD_BEEF, 3, 4'b1111, 32'h0,         32'hDEAD_BEEF);
    access(1'b1, LDST_H,  32'h102, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 4'b1100, 32'hABCD_ABCD, 32'h0);
    access(1'b1, LDST_W,  32'h104, 32'hCAFE_F00D, 32'h0,         0, 4'b1111, 32'hCAFE_F00D, 32'h0);
    access(1'b0, LDST_B,  32'h103, 32'h0,         32'h8000_0000, 0, 4'b1000, 32'h0,         32'hFFFF_FF80);
    access(1'b0, LDST_H,  32'h100, 32'h0,         32'h1234_8765, 0, 4'b0011, 32'h0,         32'hFFFF_8765);
    access(1'b0, 3'd7,    32'h100, 32'h0,         32'h1122_3344, 0, 4'b1111, 32'h0,         32'h1122_3344);

    misaligned_access(LDST_W,  32'h102);
    misaligned_access(LDST_H,  32'h101);
    misaligned_access(LDST_HU, 32'h103);
    misaligned_access(3'd3,    32'h101);

    // Reset while waiting abandons the access.
    @(posedge clk_i); #1;
    core_req_i  = 1'b1;
    core_size_i = LDST_W;
    core_addr_i = 32'h0000_0200;
    begin
      req_t e;
      e.be = 4'b1111; e.wd = 32'h0; e.we = 1'b0; e.addr = 32'h0000_0200;
      req_q.push_back(e);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("wait_rst_stall", 32'(core_stall_o), 32'd0);
    chk("wait_rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("wait_rst_rd", core_rd_o, 32'd0);
    chk("wait_rst_misalign", 32'(misalign_o), 32'd0);
    chk("wait_rst_mem_we", 32'(mem_we_o), 32'd0);
    @(posedge clk_i); #1;
    idle_inputs();
    rst_ni      = 1'b1;
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'hFFFF_FFFF;
    rsp_q.push_back(32'h0);
    @(posedge clk_i); #1;
    idle_inputs();

    repeat (2) @(posedge clk_i);
    chk("missing_mem_req", 32'(req_q.size()), 32'd0);
    chk("missing_response", 32'(rsp_q.size()), 32'd0);
    chk("missing_misalign", 32'(mis_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
